serpario_shift_ctrl: RTL and testbench

- Drives the external serial/parallel I/O expander chain: an output shift register/latch (595-type) and an input parallel-load shift register (CD4021-type, active-high parallel load).
- Sits directly downstream of the platform's register interface: takes a parallel output word plus a start strobe, and emits ser_out/sh_clk/store/out_en on the board's serpario pins.
- Shifts ser_in back in simultaneously and returns the captured parallel input word.

---
 rtl/serpario_pkg.sv | 20 ++
 rtl/serpario_tick_gen.sv | 26 ++
 rtl/serpario_shift_ctrl.sv | 163 ++++++++++++++++
 tb/tb_serpario_shift_ctrl.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/serpario_pkg.sv
// Shared types and helpers for the serial/parallel I/O expander chain controller.
package serpario_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StShiftLo,
        StShiftHi,
        StLatch,
        StDone
    } state_e;

    localparam int unsigned MIN_CLK_DIV = 1;

    // Cycles from start acceptance to the done pulse.
    function automatic int unsigned frame_latency(input int unsigned width,
                                                  input int unsigned clk_div);
        return 1 + 2 * width * clk_div + clk_div;
    endfunction

endpackage

// File: rtl/serpario_tick_gen.sv
// Phase divider: pulses tick once every CLK_DIV enabled cycles, restartable.
module serpario_tick_gen #(
    parameter int unsigned CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    input  logic enable,
    output logic tick
);

    localparam int unsigned CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CW-1:0] count;

    assign tick = enable && (count == CW'(CLK_DIV - 1));

    always_ff @(posedge clk) begin
        if (rst || restart || tick) begin
            count <= '0;
        end else if (enable) begin
            count <= count + CW'(1);
        end
    end

endmodule

// File: rtl/serpario_shift_ctrl.sv
// Serial/parallel expander chain controller (595-type out, 4021-type in).
// Optional periodic resend of the last word is enabled by SERPARIO_AUTO_REFRESH_EN.
module serpario_shift_ctrl
    import serpario_pkg::*;
#(
    parameter int unsigned WIDTH          = 16,
    parameter int unsigned CLK_DIV        = 2,
    parameter int unsigned REFRESH_CYCLES = 65536
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] out_data_i,
    input  logic             start_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] in_data_o,
    input  logic             ser_in_i,
    output logic             ser_out_o,
    output logic             sh_clk_o,
    output logic             store_o,
    output logic             out_en_o
);

    localparam int unsigned BCW = $clog2(WIDTH + 1);

    if (WIDTH < 2 || WIDTH > 64) begin : g_bad_width
        $error("serpario_shift_ctrl: WIDTH must be within 2..64");
    end
    if (CLK_DIV < MIN_CLK_DIV) begin : g_bad_div
        $error("serpario_shift_ctrl: CLK_DIV below minimum");
    end
    if (REFRESH_CYCLES < 2) begin : g_bad_refresh
        $error("serpario_shift_ctrl: REFRESH_CYCLES must be at least 2");
    end

    state_e           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [WIDTH-1:0] in_data_q, in_data_d;
    logic [BCW-1:0]   bit_cnt_q, bit_cnt_d;
    logic             cap_bit_q, cap_bit_d;
    logic             out_en_q, out_en_d;
    logic             tick;
    logic             launch;
    logic [WIDTH-1:0] launch_word;

    serpario_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick_gen (
        .clk     (clk_i),
        .rst     (rst_i),
        .restart (state_d != state_q),
        .enable  (state_q != StIdle),
        .tick    (tick)
    );

`ifdef SERPARIO_AUTO_REFRESH_EN
    logic [31:0]      refresh_cnt_q;
    logic [WIDTH-1:0] shadow_q;
    logic             armed_q;
    logic             refresh_hit;

    // Replay only once a word has actually been requested since reset.
    assign refresh_hit = armed_q && (refresh_cnt_q == 32'(REFRESH_CYCLES - 1));
    assign launch      = start_i || refresh_hit;
    assign launch_word = start_i ? out_data_i : shadow_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            refresh_cnt_q <= '0;
            shadow_q      <= '0;
            armed_q       <= 1'b0;
        end else if (state_q == StIdle) begin
            if (launch) begin
                refresh_cnt_q <= '0;
                shadow_q      <= launch_word;
                if (start_i) begin
                    armed_q <= 1'b1;
                end
            end else begin
                refresh_cnt_q <= refresh_cnt_q + 32'd1;
            end
        end
    end
`else
    assign launch      = start_i;
    assign launch_word = out_data_i;
`endif

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        cap_bit_d = cap_bit_q;
        in_data_d = in_data_q;
        out_en_d  = out_en_q;
        busy_o    = (state_q != StIdle);
        done_o    = (state_q == StDone);
        sh_clk_o  = (state_q == StShiftHi);
        store_o   = (state_q == StLatch);
        ser_out_o = 1'b0;

        case (state_q)
            StIdle: begin
                if (launch) begin
                    shreg_d   = launch_word;
                    bit_cnt_d = '0;
                    state_d   = StShiftLo;
                end
            end
            StShiftLo: begin
                ser_out_o = shreg_q[WIDTH-1];
                if (tick) begin
                    cap_bit_d = ser_in_i;
                    state_d   = StShiftHi;
                end
            end
            StShiftHi: begin
                // Data is held through the rising edge; the shift lands as the clock falls.
                ser_out_o = shreg_q[WIDTH-1];
                if (tick) begin
                    shreg_d   = {shreg_q[WIDTH-2:0], cap_bit_q};
                    bit_cnt_d = bit_cnt_q + BCW'(1);
                    state_d   = (bit_cnt_q == BCW'(WIDTH - 1)) ? StLatch : StShiftLo;
                end
            end
            StLatch: begin
                if (tick) begin
                    in_data_d = shreg_q;
                    out_en_d  = 1'b0;
                    state_d   = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= StIdle;
            shreg_q   <= '0;
            bit_cnt_q <= '0;
            cap_bit_q <= 1'b0;
            in_data_q <= '0;
            out_en_q  <= 1'b1;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
            cap_bit_q <= cap_bit_d;
            in_data_q <= in_data_d;
            out_en_q  <= out_en_d;
        end
    end

    assign in_data_o = in_data_q;
    assign out_en_o  = out_en_q;

endmodule

// File: tb/tb_serpario_shift_ctrl.sv
// Self-checking bench for serpario_shift_ctrl with behavioural 595/4021 chain models.
module tb_serpario_shift_ctrl;

    localparam int W     = 16;
    localparam int D     = 2;
    localparam int WB    = 2;
    localparam int DB    = 1;
    localparam int LAT   = 1 + 2 * W * D + D;
    localparam int LAT_B = 1 + 2 * WB * DB + DB;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic [W-1:0]  out_data, in_data;
    logic          start, busy, done, ser_in, ser_out, sh_clk, store, out_en;
    logic [WB-1:0] b_data, b_in_data;
    logic          b_start, b_busy, b_done, b_ser_out, b_sh_clk, b_store, b_out_en;
    logic          b_ser_in = 1'b0;

    serpario_shift_ctrl #(.WIDTH(W), .CLK_DIV(D), .REFRESH_CYCLES(100)) dut_a (
        .clk_i(clk), .rst_i(rst), .out_data_i(out_data), .start_i(start), .busy_o(busy),
        .done_o(done), .in_data_o(in_data), .ser_in_i(ser_in), .ser_out_o(ser_out),
        .sh_clk_o(sh_clk), .store_o(store), .out_en_o(out_en)
    );

    serpario_shift_ctrl #(.WIDTH(WB), .CLK_DIV(DB), .REFRESH_CYCLES(100)) dut_b (
        .clk_i(clk), .rst_i(rst), .out_data_i(b_data), .start_i(b_start), .busy_o(b_busy),
        .done_o(b_done), .in_data_o(b_in_data), .ser_in_i(b_ser_in), .ser_out_o(b_ser_out),
        .sh_clk_o(b_sh_clk), .store_o(b_store), .out_en_o(b_out_en)
    );

    // External chain models: 4021 loads while store is high and shifts on sh_clk rise,
    // 595 shifts ser_out in on sh_clk rise and latches on store rise.
    logic [W-1:0] preload = '0, ichain = '0, ochain = '0, olatch = '0;
    assign ser_in = ichain[W-1];
    always @(posedge sh_clk or posedge store) begin
        if (store) begin
            ichain <= preload;
            olatch <= ochain;
        end else begin
            ichain <= {ichain[W-2:0], 1'b0};
            ochain <= {ochain[W-2:0], ser_out};
        end
    end

    int          n_cmp = 0, n_fail = 0, cyc = 0, t0 = 0;
    logic [63:0] a_bits, b_bits;
    int          a_rises, b_rises, a_store_first, a_store_last, b_store_first, b_store_last;
    int          a_dones;
    logic        a_oe_latch, a_sh_prev = 1'b0, b_sh_prev = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        a_bits = '0; b_bits = '0; a_rises = 0; b_rises = 0; a_dones = 0;
        a_store_first = -1; a_store_last = -1; b_store_first = -1; b_store_last = -1;
        a_oe_latch = 1'bx;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (sh_clk && !a_sh_prev) begin
            a_bits = {a_bits[62:0], ser_out};
            a_rises++;
        end
        a_sh_prev = sh_clk;
        if (b_sh_clk && !b_sh_prev) begin
            b_bits = {b_bits[62:0], b_ser_out};
            b_rises++;
        end
        b_sh_prev = b_sh_clk;
        if (store) begin
            if (a_store_first < 0) a_store_first = cyc - t0;
            a_store_last = cyc - t0;
            a_oe_latch   = out_en;
        end
        if (b_store) begin
            if (b_store_first < 0) b_store_first = cyc - t0;
            b_store_last = cyc - t0;
        end
        if (done) a_dones++;
    endtask

    task automatic wait_a_done(input int limit, output int n);
        n = -1;
        for (int c = 1; c <= limit && n < 0; c++) begin
            step();
            if (done) n = c;
        end
        if (n < 0) check("a_done_timeout", 64'(n), 64'(limit));
    endtask

    // Starts a frame in the current (idle) cycle; returns at its done cycle.
    task automatic run_frame(input logic [W-1:0] word, input logic [W-1:0] pre,
                             input int repulse, output int done_at);
        clear_mon();
        preload  = pre;
        out_data = word;
        start    = 1'b1;
        t0       = cyc;
        done_at  = -1;
        for (int c = 1; c <= 4 * LAT && done_at < 0; c++) begin
            step();
            if (c == 1) begin
                start    = 1'b0;
                out_data = W'($urandom);
            end
            if (c == repulse) start = 1'b1;
            else if (c == repulse + 1) start = 1'b0;
            if (done) done_at = c;
        end
        if (done_at < 0) check("frame_timeout", 64'(done_at), 64'(LAT));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [W-1:0] w, w2, p, prev;
        int           d, c1;

        rst = 1'b1; start = 1'b0; out_data = '0; b_start = 1'b0; b_data = '0;
        clear_mon();
        repeat (3) step();
        check("rst_ser_out", 64'(ser_out), 64'(0));
        check("rst_sh_clk", 64'(sh_clk), 64'(0));
        check("rst_store", 64'(store), 64'(0));
        check("rst_out_en", 64'(out_en), 64'(1));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_in_data", 64'(in_data), 64'(0));
        rst = 1'b0;
        step();

        // First frame: fixed word, re-pulsed start mid-frame must be ignored.
        run_frame(16'hA5C3, 16'h3C0F, 10, d);
        check("f1_latency", 64'(d), 64'(LAT));
        check("f1_bits", a_bits[W-1:0], 64'(16'hA5C3));
        check("f1_rises", 64'(a_rises), 64'(W));
        check("f1_store_first", 64'(a_store_first), 64'(LAT - D));
        check("f1_store_last", 64'(a_store_last), 64'(LAT - 1));
        check("f1_oe_before_done", 64'(a_oe_latch), 64'(1));
        check("f1_latch", 64'(olatch), 64'(16'hA5C3));
        check("f1_done_count", 64'(a_dones), 64'(1));
        step();
        check("f1_oe_after", 64'(out_en), 64'(0));
        check("f1_busy_drop", 64'(busy), 64'(0));
        step();
        check("f1_no_queued", 64'(busy), 64'(0));

        // Second frame returns the snapshot loaded by the first store pulse.
        w = W'($urandom); p = W'($urandom);
        run_frame(w, p, -1, d);
        check("f2_latency", 64'(d), 64'(LAT));
        check("f2_in_data", 64'(in_data), 64'(16'h3C0F));
        check("f2_bits", a_bits[W-1:0], 64'(w));
        check("f2_latch", 64'(olatch), 64'(w));
        prev = p;

        for (int k = 0; k < 3; k++) begin
            step();
            w = W'($urandom); p = W'($urandom);
            run_frame(w, p, -1, d);
            check("rand_latency", 64'(d), 64'(LAT));
            check("rand_bits", a_bits[W-1:0], 64'(w));
            check("rand_in_data", 64'(in_data), 64'(prev));
            check("rand_latch", 64'(olatch), 64'(w));
            prev = p;
        end

        // start_i held high: back-to-back frames with a single idle cycle.
        step();
        clear_mon();
        w = W'($urandom); out_data = w; start = 1'b1;
        wait_a_done(4 * LAT, d);
        check("hold_latency", 64'(d), 64'(LAT));
        c1 = cyc; w2 = ~w; out_data = w2;
        step();
        check("hold_idle_gap", 64'(busy), 64'(0));
        step();
        check("hold_restart", 64'(busy), 64'(1));
        start = 1'b0;
        wait_a_done(4 * LAT, d);
        check("hold_period", 64'(cyc - c1), 64'(LAT + 1));
        check("hold_bits", a_bits[W-1:0], 64'(w2));

        // Reset at cycle 30 of a frame.
        step();
        out_data = W'($urandom); start = 1'b1;
        step();
        start = 1'b0;
        repeat (29) step();
        rst = 1'b1;
        step();
        check("mid_rst_out_en", 64'(out_en), 64'(1));
        check("mid_rst_sh_clk", 64'(sh_clk), 64'(0));
        check("mid_rst_store", 64'(store), 64'(0));
        check("mid_rst_busy", 64'(busy), 64'(0));
        check("mid_rst_ser_out", 64'(ser_out), 64'(0));
        check("mid_rst_in_data", 64'(in_data), 64'(0));
        rst = 1'b0;
        step();

        // Narrowest chain at the fastest divider.
        clear_mon();
        b_data = 2'b10; b_start = 1'b1; t0 = cyc; d = -1;
        for (int c = 1; c <= 20 && d < 0; c++) begin
            step();
            if (c == 1) begin
                b_start = 1'b0;
                b_data  = 2'b01;
            end
            if (b_done) d = c;
        end
        check("b_latency", 64'(d), 64'(LAT_B));
        check("b_rises", 64'(b_rises), 64'(WB));
        check("b_bits", 64'(b_bits[WB-1:0]), 64'(2'b10));
        check("b_store_first", 64'(b_store_first), 64'(LAT_B - DB));
        check("b_store_last", 64'(b_store_last), 64'(LAT_B - 1));
        step();
        check("b_oe_after", 64'(b_out_en), 64'(0));

`ifdef SERPARIO_AUTO_REFRESH_EN
        // Auto refresh: 100 idle cycles after done, the last word is resent.
        step();
        w = W'($urandom);
        run_frame(w, W'($urandom), -1, d);
        check("ar_first_latency", 64'(d), 64'(LAT));
        clear_mon();
        out_data = ~w;
        repeat (100) step();
        check("ar_still_idle", 64'(busy), 64'(0));
        step();
        check("ar_launched", 64'(busy), 64'(1));
        wait_a_done(4 * LAT, d);
        check("ar_latency", 64'(d), 64'(LAT - 1));
        check("ar_bits", a_bits[W-1:0], 64'(w));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
